// File: rtl/adder_pkg.sv
// Shared types for the pipelined ripple-carry adder: operation encoding,
// per-stage control payload and the chunk-width helper.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Control half of a stage payload; the operand/sum words travel alongside
    // as WIDTH-bit vectors because their widths depend on the instance parameters.
    typedef struct packed {
        logic valid;
        logic carry;
        op_e  op;
    } stage_ctrl_t;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One elastic pipeline stage: adds chunk K of the skewed operands and forwards
// the remaining operand chunks, the partial sum and the carry to the next stage.
module adder_chunk_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CW    = 4,
    parameter int K     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  stage_ctrl_t       in_ctrl,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [WIDTH-1:0]  in_sum,
    output stage_ctrl_t       out_ctrl,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [WIDTH-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int LO = K * CW;

    stage_ctrl_t      ctrl_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             ovf_reg;

    logic [CW-1:0]    a_chunk;
    logic [CW-1:0]    b_chunk;
    logic [CW:0]      chunk_sum;
    logic             carry_into_msb;
    logic [WIDTH-1:0] sum_next;

    // Operands arrive pre-shifted so the chunk for this stage sits in the LSBs.
    assign a_chunk   = in_a[CW-1:0];
    assign b_chunk   = (in_ctrl.op == OP_SUB) ? ~in_b[CW-1:0] : in_b[CW-1:0];
    assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CW{1'b0}}, in_ctrl.carry};

    assign carry_into_msb = a_chunk[CW-1] ^ b_chunk[CW-1] ^ chunk_sum[CW-1];
    assign sum_next       = in_sum | (WIDTH'(chunk_sum[CW-1:0]) << LO);

    assign in_ready = ~ctrl_reg.valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_reg <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            ovf_reg  <= 1'b0;
        end else if (in_ready) begin
            ctrl_reg.valid <= in_ctrl.valid;
            if (in_ctrl.valid) begin
                ctrl_reg.carry <= chunk_sum[CW];
                ctrl_reg.op    <= in_ctrl.op;
                a_reg          <= in_a >> CW;
                b_reg          <= in_b >> CW;
                sum_reg        <= sum_next;
                ovf_reg        <= carry_into_msb ^ chunk_sum[CW];
            end
        end
    end

    assign out_ctrl = ctrl_reg;
    assign out_a    = a_reg;
    assign out_b    = b_reg;
    assign out_sum  = sum_reg;
    assign out_ovf  = ovf_reg;

endmodule

// File: rtl/pipelined_rc_adder.sv
// Parametrised pipelined ripple-carry adder/subtractor with valid/ready flow
// control; STAGES chunk stages, each adding WIDTH/STAGES bits per cycle.
module pipelined_rc_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_cin,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_sum,
    output logic              out_cout,
    output logic              out_ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_rc_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    stage_ctrl_t      ctrl_w [STAGES+1];
    logic             rdy_w  [STAGES+1];
    logic [WIDTH-1:0] a_w    [STAGES+1];
    logic [WIDTH-1:0] b_w    [STAGES+1];
    logic [WIDTH-1:0] sum_w  [STAGES+1];
    logic             ovf_w  [STAGES];

    assign ctrl_w[0] = '{valid: in_valid, carry: in_cin, op: (in_sub ? OP_SUB : OP_ADD)};
    assign a_w[0]    = in_a;
    assign b_w[0]    = in_b;
    assign sum_w[0]  = '0;
    assign in_ready  = rdy_w[0];

    // The ready chain runs backwards combinationally from the consumer.
    assign rdy_w[STAGES] = out_ready;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        adder_chunk_stage #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .K     (gi)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_ctrl   (ctrl_w[gi]),
            .in_ready  (rdy_w[gi]),
            .in_a      (a_w[gi]),
            .in_b      (b_w[gi]),
            .in_sum    (sum_w[gi]),
            .out_ctrl  (ctrl_w[gi+1]),
            .out_ready (rdy_w[gi+1]),
            .out_a     (a_w[gi+1]),
            .out_b     (b_w[gi+1]),
            .out_sum   (sum_w[gi+1]),
            .out_ovf   (ovf_w[gi])
        );
    end

    assign out_valid = ctrl_w[STAGES].valid;
    assign out_cout  = ctrl_w[STAGES].carry;
    assign out_sum   = sum_w[STAGES];
    assign out_ovf   = ovf_w[STAGES-1];

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Scoreboard bench for pipelined_rc_adder (WIDTH=16, STAGES=4): directed
// vectors, backpressure, full-rate random stream and mid-flight reset.
module tb_pipelined_rc_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    pipelined_rc_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] exp;
        int          cyc;
    } sb_t;

    sb_t         sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          chk_lat  = 1'b0;
    bit          stall_prev = 1'b0;
    logic [17:0] stall_val;
    logic [17:0] last_out;

    // Reference result packed as {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bx;
        logic [16:0] full;
        logic        ovf;
        bx   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {16'd0, cin};
        ovf  = (a[15] == bx[15]) && (full[15] != a[15]);
        return {ovf, full[16], full[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then return #1 after the rising edge.
    task automatic cycle(output bit acc);
        sb_t e;
        @(negedge clk);
        cyc++;
        if (stall_prev) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {14'd0, out_ovf, out_cout, out_sum}, {14'd0, stall_val});
        end
        acc = in_valid && in_ready;
        if (acc) begin
            sb.push_back('{exp: model(in_a, in_b, in_cin, in_sub), cyc: cyc});
            $display("t=%0t in  a=%h b=%h cin=%0b sub=%0b", $time, in_a, in_b, in_cin, in_sub);
        end
        if (out_valid && out_ready) begin
            last_out = {out_ovf, out_cout, out_sum};
            $display("t=%0t out sum=%h cout=%0b ovf=%0b", $time, out_sum, out_cout, out_ovf);
            if (sb.size() == 0) begin
                check("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", {14'd0, last_out}, {14'd0, e.exp});
                if (chk_lat) check("latency", cyc - e.cyc, STAGES);
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_val  = {out_ovf, out_cout, out_sum};
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
    endtask

    task automatic drain(input int budget);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < budget && sb.size() > 0; i++) cycle(acc);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic sub, input logic [17:0] want);
        bit acc;
        drive(a, b, cin, sub);
        cycle(acc);
        check("dir_accept", {31'd0, acc}, 32'd1);
        drain(12);
        check("dir_result", {14'd0, last_out}, {14'd0, want});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          acc;
        int          idx;
        int          n_acc;
        logic [15:0] bp_a [8];
        logic [15:0] bp_b [8];
        logic        bp_s [8];

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("rst_out_cout", {31'd0, out_cout}, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Directed spec vectors; expected values written as {ovf, cout, sum}.
        chk_lat = 1'b1;
        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        directed(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        directed(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});

        // Backpressure: consumer stalls from the third cycle of the stream.
        chk_lat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = 16'($urandom);
            bp_b[i] = 16'($urandom);
            bp_s[i] = 1'($urandom);
        end
        idx = 0;
        drive(bp_a[0], bp_b[0], bp_s[0], bp_s[0]);
        for (int c = 0; c < 10; c++) begin
            if (c == 2) out_ready = 1'b0;
            cycle(acc);
            if (acc) begin
                idx++;
                drive(bp_a[idx], bp_b[idx], bp_s[idx], bp_s[idx]);
            end
        end
        check("bp_accepted", idx, STAGES);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_fill_while_drain", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 40 && idx < 8; c++) begin
            cycle(acc);
            if (acc) begin
                idx++;
                if (idx < 8) drive(bp_a[idx], bp_b[idx], bp_s[idx], bp_s[idx]);
            end
        end
        check("bp_all_accepted", idx, 8);
        drain(20);

        // Full-rate random stream with mixed add/sub.
        chk_lat = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            cycle(acc);
            if (acc) n_acc++;
        end
        check("full_rate_accepts", n_acc, 1000);
        drain(12);

        // Reset with beats in flight.
        for (int i = 0; i < 3; i++) begin
            drive(16'($urandom), 16'($urandom), 1'b0, 1'b0);
            cycle(acc);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("rf_out_valid_before", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rf_out_valid", {31'd0, out_valid}, 32'd0);
        check("rf_out_sum", {16'd0, out_sum}, 32'd0);
        sb.delete();
        stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(acc);
            check("rf_no_stale", {31'd0, out_valid}, 32'd0);
        end
        directed(16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
